// File: rtl/mtos_connection_pkg.sv
// mtos_connection_pkg: route codes, peripheral indices and dispatcher FSM states shared by the master-to-serial path
package mtos_connection_pkg;
  localparam logic [4:0] CTRL_UART       = 5'b00000;
  localparam logic [4:0] CTRL_I2C        = 5'b00001;
  localparam logic [4:0] CTRL_SPI        = 5'b00010;
  localparam logic [4:0] CTRL_CAN        = 5'b00011;
  localparam logic [4:0] CTRL_BT         = 5'b00110;
  localparam logic [4:0] CTRL_IR         = 5'b00111;
  localparam logic [4:0] CTRL_I2C_SLAVE  = 5'b01001;
  localparam logic [4:0] CTRL_SPI_SLAVE  = 5'b01010;
  localparam logic [4:0] CTRL_BRIDGE     = 5'b01111;
  localparam logic [2:0] PI_UART      = 3'd0;
  localparam logic [2:0] PI_I2C       = 3'd1;
  localparam logic [2:0] PI_SPI       = 3'd2;
  localparam logic [2:0] PI_CAN       = 3'd3;
  localparam logic [2:0] PI_BT        = 3'd4;
  localparam logic [2:0] PI_IR        = 3'd5;
  localparam logic [2:0] PI_I2C_SLAVE = 3'd6;
  localparam logic [2:0] PI_SPI_SLAVE = 3'd7;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_START} state_t;
endpackage

// File: rtl/mtos_connection_route_decode.sv
// mtos_route_decode: maps ctrl_signal to {valid, source, peripheral index}; bit4 picks the source only
module mtos_route_decode
  import mtos_connection_pkg::*;
(
  input  logic [4:0] ctrl_signal,
  output logic       valid,
  output logic       src,
  output logic [2:0] idx
);
  logic [3:0] code;
  always_comb begin
    code  = ctrl_signal[3:0];
    src   = ctrl_signal[4];
    idx   = code == CTRL_I2C[3:0]       ? PI_I2C :
            code == CTRL_SPI[3:0]       ? PI_SPI :
            code == CTRL_CAN[3:0]       ? PI_CAN :
            code == CTRL_BT[3:0]        ? PI_BT :
            code == CTRL_IR[3:0]        ? PI_IR :
            code == CTRL_I2C_SLAVE[3:0] ? PI_I2C_SLAVE :
            code == CTRL_SPI_SLAVE[3:0] ? PI_SPI_SLAVE : PI_UART;
    valid = idx != PI_UART || code == CTRL_UART[3:0];
  end
endmodule

// File: rtl/mtos_connection.sv
// mtos_connection: drains a completed USB/Ethernet RX packet byte by byte into the selected peripheral TX FIFO, then starts it
module mtos_connection
  import mtos_connection_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ctrl_signal,
  input  logic             usb_rx_cpl,
  input  logic [CNT_W-1:0] usb_rx_datalength,
  input  logic [7:0]       usb_rdfifo_data,
  input  logic             usb_rdfifo_empty,
  output logic             usb_rdfifo_rd,
  input  logic             eth_rx_cpl,
  input  logic [CNT_W-1:0] eth_rx_datalength,
  input  logic [7:0]       eth_rdfifo_data,
  input  logic             eth_rdfifo_empty,
  output logic             eth_rdfifo_rd,
  output logic [7:0]       periph_wrfifo_data,
  output logic [7:0]       periph_wrfifo_pulse,
  output logic [7:0]       periph_tx_en,
  output logic [CNT_W-1:0] periph_tx_datalength,
  input  logic [7:0]       periph_tx_busy,
  output logic             busy,
  output logic             err_pulse
);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic r_valid, r_src, src_q, src_n, rd_n, err_n;
  logic [2:0] r_idx, idx_q, idx_n;
  logic [7:0] data_n, wr_n, en_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, stall, stall_n, len_n;
  mtos_route_decode u_decode (.ctrl_signal(ctrl_signal), .valid(r_valid), .src(r_src), .idx(r_idx));
  wire sel_cpl = ctrl_signal[4] ? eth_rx_cpl : usb_rx_cpl;
  wire [CNT_W-1:0] sel_len = ctrl_signal[4] ? eth_rx_datalength : usb_rx_datalength;
  wire cur_cpl = src_q ? eth_rx_cpl : usb_rx_cpl;
  wire fifo_empty = src_q ? eth_rdfifo_empty : usb_rdfifo_empty;
  wire [7:0] fifo_data = src_q ? eth_rdfifo_data : usb_rdfifo_data;
  assign cnt_inc = cnt + 1'b1;
  assign busy = state != S_IDLE;
  always_comb begin
    state_n = state;
    src_n   = src_q;
    idx_n   = idx_q;
    len_n   = periph_tx_datalength;
    cnt_n   = cnt;
    stall_n = stall;
    rd_n    = 1'b0;
    data_n  = '0;
    wr_n    = '0;
    en_n    = '0;
    err_n   = busy && cur_cpl;
    case (state)
      S_IDLE: if (sel_cpl && r_valid) begin
        if (sel_len != '0 && !periph_tx_busy[r_idx]) begin
          state_n = S_READ;
          src_n   = r_src;
          idx_n   = r_idx;
          len_n   = sel_len;
          cnt_n   = '0;
          stall_n = '0;
        end else err_n = 1'b1;
      end
      S_READ: if (!fifo_empty) begin
        rd_n    = 1'b1;
        stall_n = '0;
        state_n = S_WAIT;
      end else if (stall == STALL_LAST) begin
        err_n   = 1'b1;
        stall_n = '0;
        state_n = S_IDLE;
      end else stall_n = stall + 1'b1;
      S_WAIT: state_n = S_WRITE;
      S_WRITE: begin
        data_n  = fifo_data;
        wr_n    = 8'd1 << idx_q;
        cnt_n   = cnt_inc;
        state_n = cnt_inc == periph_tx_datalength ? S_START : S_READ;
      end
      S_START: begin
        en_n    = 8'd1 << idx_q;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      src_q                <= 1'b0;
      idx_q                <= '0;
      cnt                  <= '0;
      stall                <= '0;
      periph_tx_datalength <= '0;
      usb_rdfifo_rd        <= 1'b0;
      eth_rdfifo_rd        <= 1'b0;
      periph_wrfifo_data   <= '0;
      periph_wrfifo_pulse  <= '0;
      periph_tx_en         <= '0;
      err_pulse            <= 1'b0;
    end else begin
      state                <= state_n;
      src_q                <= src_n;
      idx_q                <= idx_n;
      cnt                  <= cnt_n;
      stall                <= stall_n;
      periph_tx_datalength <= len_n;
      usb_rdfifo_rd        <= rd_n && !src_n;
      eth_rdfifo_rd        <= rd_n && src_n;
      periph_wrfifo_data   <= data_n;
      periph_wrfifo_pulse  <= wr_n;
      periph_tx_en         <= en_n;
      err_pulse            <= err_n;
    end
  end
endmodule

// File: doc/mtos_connection.md
Name: mtos_connection

Overview:
Master-to-serial dispatcher; the downstream counterpart of the serial-to-master collector. When a packet finishes arriving in the USB or Ethernet RX FIFO, this block drains it byte by byte. Each byte goes into the write FIFO of the peripheral transmitter selected by ctrl_signal (UART, I2C, SPI, CAN, Bluetooth, IR, I2C slave, SPI slave). After the last byte it fires that peripheral's tx_en together with the packet length. It sits between the host-link RX FIFOs and the peripheral TX modules.

Parameters:
TIMEOUT_CYCLES, 65535, maximum number of consecutive cycles the source FIFO may stay empty mid-packet before the transfer is aborted.
CNT_W, 16, width of the byte counter and of the length fields.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ctrl_signal  in  5  route select; bit4 = 0 selects USB as source, 1 selects Ethernet; bits[3:0] select the target peripheral
usb_rx_cpl  in  1  one-cycle pulse: a USB packet is complete in the USB RX FIFO
usb_rx_datalength  in  16  USB packet length in bytes, valid with usb_rx_cpl
usb_rdfifo_data  in  8  USB RX FIFO output; valid the cycle after a read
usb_rdfifo_empty  in  1  USB RX FIFO empty
usb_rdfifo_rd  out  1  USB RX FIFO read strobe
eth_rx_cpl, eth_rx_datalength, eth_rdfifo_data, eth_rdfifo_empty, eth_rdfifo_rd  same as the USB group, for Ethernet
periph_wrfifo_data  out  8  byte bus shared by all peripherals
periph_wrfifo_pulse  out  8  one-hot write strobe per peripheral
periph_tx_en  out  8  one-hot start pulse per peripheral
periph_tx_datalength  out  16  packet length, shared
periph_tx_busy  in  8  per-peripheral transmitter busy
busy  out  1  high whenever the FSM is not in IDLE
err_pulse  out  1  one-cycle pulse on any dropped or aborted packet

Behaviour:
- Target index mapping (bits[3:0] of ctrl_signal → peripheral index):
  - 0000 → 0 (UART), 0001 → 1 (I2C), 0010 → 2 (SPI), 0011 → 3 (CAN)
  - 0110 → 4 (Bluetooth), 0111 → 5 (IR), 1001 → 6 (I2C slave), 1010 → 7 (SPI slave)
  - Any other code, including 01111/11111 (USB↔Ethernet bridge, handled elsewhere), is "no route": rx_cpl is ignored and nothing is read.
- Reset: all outputs 0, FSM in IDLE, counters 0, latched route 0.
- FSM states: IDLE, READ, WAIT, WRITE, START.
- IDLE:
  - Only the rx_cpl of the currently selected source is sampled.
  - If the route is valid, the length is nonzero and periph_tx_busy[target] = 0: latch source, target and length; clear the counter; go to READ.
  - If the length is 0 or the target is busy: err_pulse for one cycle, stay in IDLE, read nothing.
- READ:
  - If the source FIFO is not empty: rd <= 1 and go to WAIT.
  - Otherwise increment the stall counter. When it reaches TIMEOUT_CYCLES: err_pulse, go to IDLE, no tx_en.
  - The stall counter clears on every read.
- WAIT: rd <= 0; go to WRITE (FIFO data is valid during WRITE).
- WRITE:
  - Register rdfifo_data into periph_wrfifo_data and set periph_wrfifo_pulse[target] <= 1 for one cycle.
  - Increment the counter. If counter+1 == length, go to START; otherwise go to READ.
- START: periph_tx_en[target] <= 1 for one cycle; go to IDLE.
- periph_tx_datalength is loaded at acceptance and held until the next acceptance.
- Timing:
  - rd goes high 2 cycles after rx_cpl is sampled.
  - The first wrfifo pulse arrives 4 cycles after rx_cpl.
  - Byte pitch is 3 cycles with the FIFO non-empty.
  - tx_en arrives exactly 1 cycle after the last wrfifo pulse.
- ctrl_signal and both rx_cpl inputs are ignored outside IDLE. An rx_cpl on the selected source while busy produces err_pulse; the packet stays in the FIFO.
- Simultaneous usb_rx_cpl and eth_rx_cpl: only the source selected by bit4 is considered.
- Only one bit of periph_wrfifo_pulse or periph_tx_en is ever high at a time; all data bits are 0 when no pulse is active.
- rst asserted mid-packet: immediate return to IDLE, all strobes cleared; partial data is already in the peripheral FIFO and no tx_en is issued.

Decomposition:
- Shared package holds:
  - ctrl code constants (CTRL_UART = 5'b00000 … CTRL_BRIDGE = 5'b01111)
  - peripheral index constants PI_UART … PI_SPI_SLAVE
  - the FSM state enum
- One sub-module, mtos_route_decode: combinational ctrl_signal → {valid, src, idx[2:0]}, shared with future routing blocks.

Test Plan:
- ctrl = 00000, usb_rx_cpl with length 3, FIFO holds A1 B2 C3 → periph_wrfifo_pulse[0] three times with data A1, B2, C3 at 3-cycle pitch; then periph_tx_en[0] one cycle later with datalength 3; usb_rdfifo_rd pulses exactly 3 times.
- ctrl = 11010, eth_rx_cpl with length 1, byte 5A → only bit 7 strobes; usb_rdfifo_rd stays 0.
- ctrl = 00011, usb_rx_cpl with length 0, and separately with periph_tx_busy[3] = 1 → err_pulse, no rd, no tx_en.
- FIFO empty mid-packet for TIMEOUT_CYCLES (set to 8) after 2 of 4 bytes → err_pulse, return to IDLE, no tx_en; the next packet is processed normally.
- ctrl changed from 00000 to 10001 mid-transfer → the packet completes on UART; the next eth packet routes to I2C.
- rst pulsed during WAIT → all outputs 0 next cycle, busy = 0; ctrl = 01111 with rx_cpl → no activity.
